// File: rtl/wb_master_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM state
// encodings, grant codes, default watchdog limit and counter width.
package wb_master_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  // grant_o codes: {m1 granted, m0 granted}
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // Default watchdog limit in wb_clk cycles and width of its counter
  localparam int DEFAULT_TIMEOUT = 255;
  localparam int WDOG_W          = 16;

  // Grant vector is a pure decode of the FSM state
  function automatic logic [1:0] grant_of(input arb_state_t s);
    logic [1:0] g;
    case (s)
      ST_OWN0: g = GRANT_M0;
      ST_OWN1: g = GRANT_M1;
      default: g = GRANT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Watchdog for the arbiter: counts stalled strobe cycles and flags an
// abort on the cycle the count reaches TIMEOUT-1 with no slave response.
// Only instantiated when WB_ARB_WATCHDOG_EN is defined.
module wb_arb_watchdog
  import wb_master_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic active,   // owner's cyc & stb are on the slave port
  input  logic resp,     // slave ack | err | rty this cycle
  input  logic clear,    // idle or owner releasing
  output logic expired   // abort this cycle
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT - 1);

  logic [WDOG_W-1:0] count;

  // A response in the limit cycle masks the abort, so ack always wins
  assign expired = active && !resp && (count == LIMIT);

  // Stall counter: restarts on any response, release, idle or abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || resp || expired) begin
      count <= '0;
    end else if (active) begin
      count <= count + WDOG_W'(1);
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master round-robin Wishbone arbiter sharing one bus-matrix port.
// The grant is held for the owner's whole cyc_i; handover to a waiting
// master happens on the release edge with no idle cycle in between.
// Optional feature: define WB_ARB_WATCHDOG_EN to abort hung slave
// accesses with err and a one-cycle timeout_o pulse.
module wb_master_arbiter
  import wb_master_arbiter_pkg::*;
#(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  // master 0
  input  logic [aw-1:0] m0_adr_i,
  input  logic [dw-1:0] m0_dat_i,
  input  logic [3:0]    m0_sel_i,
  input  logic          m0_we_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic [2:0]    m0_cti_i,
  input  logic [1:0]    m0_bte_i,
  output logic [dw-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic          m0_rty_o,
  // master 1
  input  logic [aw-1:0] m1_adr_i,
  input  logic [dw-1:0] m1_dat_i,
  input  logic [3:0]    m1_sel_i,
  input  logic          m1_we_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic [2:0]    m1_cti_i,
  input  logic [1:0]    m1_bte_i,
  output logic [dw-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          m1_rty_o,
  // shared slave-side port
  output logic [aw-1:0] s_adr_o,
  output logic [dw-1:0] s_dat_o,
  output logic [3:0]    s_sel_o,
  output logic          s_we_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic [2:0]    s_cti_o,
  output logic [1:0]    s_bte_o,
  input  logic [dw-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  input  logic          s_rty_i,
  // status
  output logic [1:0]    grant_o,
  output logic          timeout_o
);

  arb_state_t state_reg, state_next;
  logic       last_owner_reg, last_owner_next;  // 0 = m0, 1 = m1
  logic       own0, own1;
  logic       release_now;
  logic       owner_stb;
  logic       abort;

  assign own0        = (state_reg == ST_OWN0);
  assign own1        = (state_reg == ST_OWN1);
  assign release_now = (own0 && !m0_cyc_i) || (own1 && !m1_cyc_i);

  // State and round-robin history; reset drops the grant immediately
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_reg      <= ST_IDLE;
      last_owner_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      last_owner_reg <= last_owner_next;
    end
  end

  // Next-state: grant from idle, hold while owner's cyc is high, hand over on release
  always_comb begin
    state_next      = state_reg;
    last_owner_next = last_owner_reg;
    case (state_reg)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_next = last_owner_reg ? ST_OWN0 : ST_OWN1;
        end else if (m0_cyc_i) begin
          state_next = ST_OWN0;
        end else if (m1_cyc_i) begin
          state_next = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (!m0_cyc_i) begin
          last_owner_next = 1'b0;
          state_next      = m1_cyc_i ? ST_OWN1 : ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (!m1_cyc_i) begin
          last_owner_next = 1'b1;
          state_next      = m0_cyc_i ? ST_OWN0 : ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Slave-side mux: forward the owner's request, everything 0 when idle
  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    s_cyc_o   = 1'b0;
    owner_stb = 1'b0;
    s_cti_o   = '0;
    s_bte_o   = '0;
    case (state_reg)
      ST_OWN0: begin
        s_adr_o   = m0_adr_i;
        s_dat_o   = m0_dat_i;
        s_sel_o   = m0_sel_i;
        s_we_o    = m0_we_i;
        s_cyc_o   = m0_cyc_i;
        owner_stb = m0_stb_i;
        s_cti_o   = m0_cti_i;
        s_bte_o   = m0_bte_i;
      end
      ST_OWN1: begin
        s_adr_o   = m1_adr_i;
        s_dat_o   = m1_dat_i;
        s_sel_o   = m1_sel_i;
        s_we_o    = m1_we_i;
        s_cyc_o   = m1_cyc_i;
        owner_stb = m1_stb_i;
        s_cti_o   = m1_cti_i;
        s_bte_o   = m1_bte_i;
      end
      default: ;
    endcase
  end

`ifdef WB_ARB_WATCHDOG_EN
  logic wd_active;
  logic wd_resp;
  logic wd_clear;

  // The watchdog sees the un-gated strobe so the abort cannot feed back on itself
  assign wd_active = s_cyc_o && owner_stb;
  assign wd_resp   = s_ack_i || s_err_i || s_rty_i;
  assign wd_clear  = (state_reg == ST_IDLE) || release_now;

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (wb_clk),
    .rst     (wb_rst),
    .active  (wd_active),
    .resp    (wd_resp),
    .clear   (wd_clear),
    .expired (abort)
  );
`else
  // Without the watchdog TIMEOUT has no effect; keep it referenced.
  localparam logic [15:0] unused_timeout = 16'(TIMEOUT);
  logic unused_release;
  assign unused_release = release_now;
  assign abort = 1'b0;
`endif

  // Abort withdraws the strobe for the cycle it fires; the grant itself holds
  assign s_stb_o   = owner_stb && !abort;
  assign timeout_o = abort;
  assign grant_o   = grant_of(state_reg);

  // Responses reach only the owner; read data is broadcast
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = own0 && s_ack_i;
  assign m0_err_o = own0 && (s_err_i || abort);
  assign m0_rty_o = own0 && s_rty_i;
  assign m1_ack_o = own1 && s_ack_i;
  assign m1_err_o = own1 && (s_err_i || abort);
  assign m1_rty_o = own1 && s_rty_i;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed self-checking bench for wb_master_arbiter (TIMEOUT=8).
// Exercises the WB_ARB_WATCHDOG_EN path when that macro is defined.
module tb_wb_master_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
`ifdef WB_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic          wb_clk, wb_rst;
  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic [3:0]    m0_sel_i, m1_sel_i, s_sel_o;
  logic          m0_we_i, m1_we_i, s_we_o;
  logic          m0_cyc_i, m1_cyc_i, s_cyc_o;
  logic          m0_stb_i, m1_stb_i, s_stb_o;
  logic [2:0]    m0_cti_i, m1_cti_i, s_cti_o;
  logic [1:0]    m0_bte_i, m1_bte_i, s_bte_o;
  logic          m0_ack_o, m0_err_o, m0_rty_o;
  logic          m1_ack_o, m1_err_o, m1_rty_o;
  logic          s_ack_i, s_err_i, s_rty_i;
  logic [1:0]    grant_o;
  logic          timeout_o;

  int checks = 0;
  int failures = 0;

  wb_master_arbiter #(.dw(DW), .aw(AW), .TIMEOUT(8)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge
  task automatic next_cycle();
    @(posedge wb_clk);
    #2;
  endtask

  initial begin
    wb_rst = 1'b1;
    m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    m0_cti_i = '0; m0_bte_i = '0;
    m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    m1_cti_i = '0; m1_bte_i = '0;
    s_dat_i = '0; s_ack_i = 0; s_err_i = 0; s_rty_i = 0;

    // ---- reset state, even with a request pending ----
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'hDEAD_0000;
    next_cycle(); next_cycle();
    check("rst_grant", grant_o, 2'b00);
    check("rst_s_cyc", s_cyc_o, 1'b0);
    check("rst_s_stb", s_stb_o, 1'b0);
    check("rst_s_adr", s_adr_o, 32'h0);
    check("rst_timeout", timeout_o, 1'b0);
    check("rst_m0_ack", m0_ack_o, 1'b0);
    m0_cyc_i = 0; m0_stb_i = 0; m0_adr_i = '0;
    wb_rst = 1'b0;
    next_cycle();

    // ---- 1: m0 single read, slave acks two cycles after grant ----
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_1000; m0_sel_i = 4'hF; m0_we_i = 0;
    #1;
    check("t1_latency_grant", grant_o, 2'b00);
    check("t1_latency_cyc", s_cyc_o, 1'b0);
    next_cycle();
    check("t1_grant", grant_o, 2'b01);
    check("t1_s_cyc", s_cyc_o, 1'b1);
    check("t1_s_stb", s_stb_o, 1'b1);
    check("t1_s_adr", s_adr_o, 32'h0000_1000);
    check("t1_s_sel", s_sel_o, 4'hF);
    check("t1_no_ack_yet", m0_ack_o, 1'b0);
    next_cycle();
    s_ack_i = 1; s_dat_i = 32'hCAFE_BABE;
    #1;
    check("t1_m0_ack", m0_ack_o, 1'b1);
    check("t1_m0_dat", m0_dat_o, 32'hCAFE_BABE);
    check("t1_m1_ack", m1_ack_o, 1'b0);
    next_cycle();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    #1;
    check("t1_ack_once", m0_ack_o, 1'b0);
    check("t1_cyc_drop", s_cyc_o, 1'b0);
    next_cycle();
    check("t1_idle_grant", grant_o, 2'b00);
    check("t1_idle_adr", s_adr_o, 32'h0);

    // ---- 2: simultaneous requests out of reset, alternation ----
    wb_rst = 1; #1;
    wb_rst = 0;
    next_cycle();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'hA000_0000;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'hB000_0000;
    next_cycle();
    check("t2_first_m0", grant_o, 2'b01);
    check("t2_first_adr", s_adr_o, 32'hA000_0000);
    m0_cyc_i = 0; m0_stb_i = 0;
    next_cycle();
    check("t2_handover_m1", grant_o, 2'b10);
    check("t2_handover_adr", s_adr_o, 32'hB000_0000);
    m0_cyc_i = 1; m0_stb_i = 1;
    next_cycle();
    check("t2_m1_holds", grant_o, 2'b10);
    m1_cyc_i = 0; m1_stb_i = 0;
    next_cycle();
    check("t2_back_m0", grant_o, 2'b01);
    m1_cyc_i = 1; m1_stb_i = 1; m0_cyc_i = 0; m0_stb_i = 0;
    next_cycle();
    check("t2_again_m1", grant_o, 2'b10);
    m1_cyc_i = 0; m1_stb_i = 0;
    next_cycle();
    check("t2_idle", grant_o, 2'b00);

    // ---- 3: m0 4-beat burst while m1 waits ----
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_0100; m0_cti_i = 3'b010;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h0000_0200; m1_cti_i = 3'b000;
    next_cycle();
    check("t3_grant_m0", grant_o, 2'b01);
    for (int b = 0; b < 4; b++) begin
      m0_adr_i = 32'h0000_0100 + 32'(4 * b);
      m0_cti_i = (b == 3) ? 3'b111 : 3'b010;
      s_ack_i = 1; s_dat_i = 32'h1111_0000 + 32'(b);
      #1;
      check($sformatf("t3_beat%0d_m0_ack", b), m0_ack_o, 1'b1);
      check($sformatf("t3_beat%0d_m1_ack", b), m1_ack_o, 1'b0);
      check($sformatf("t3_beat%0d_adr", b), s_adr_o, 32'h0000_0100 + 32'(4 * b));
      check($sformatf("t3_beat%0d_cti", b), s_cti_o, (b == 3) ? 3'b111 : 3'b010);
      check($sformatf("t3_beat%0d_grant", b), grant_o, 2'b01);
      next_cycle();
    end
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_cti_i = 3'b000;
    #1;
    check("t3_release_grant", grant_o, 2'b01);
    check("t3_release_cyc", s_cyc_o, 1'b0);
    next_cycle();
    check("t3_m1_granted", grant_o, 2'b10);
    check("t3_m1_adr", s_adr_o, 32'h0000_0200);
    check("t3_m1_cyc", s_cyc_o, 1'b1);

    // ---- 4: err then rty to m1 ----
    s_err_i = 1;
    #1;
    check("t4_m1_err", m1_err_o, 1'b1);
    check("t4_m0_err", m0_err_o, 1'b0);
    check("t4_m1_ack", m1_ack_o, 1'b0);
    next_cycle();
    s_err_i = 0; s_rty_i = 1;
    #1;
    check("t4_m1_rty", m1_rty_o, 1'b1);
    check("t4_m0_rty", m0_rty_o, 1'b0);
    check("t4_m1_err_clr", m1_err_o, 1'b0);
    next_cycle();
    s_rty_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    #1;
    check("t4_m1_rty_clr", m1_rty_o, 1'b0);
    next_cycle();
    check("t4_idle", grant_o, 2'b00);

    // ---- 5: slave never responds (watchdog if built in) ----
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_5000;
    for (int i = 1; i <= 9; i++) begin
      next_cycle();
      #1;
      check($sformatf("t5_c%0d_err", i), m0_err_o, WD && (i == 8));
      check($sformatf("t5_c%0d_timeout", i), timeout_o, WD && (i == 8));
      check($sformatf("t5_c%0d_stb", i), s_stb_o, !(WD && (i == 8)));
      check($sformatf("t5_c%0d_grant", i), grant_o, 2'b01);
    end
    m0_cyc_i = 0; m0_stb_i = 0;
    next_cycle();
    check("t5_idle", grant_o, 2'b00);
    // same run, slave acks in the limit cycle
    m0_cyc_i = 1; m0_stb_i = 1;
    for (int i = 1; i <= 8; i++) begin
      next_cycle();
      if (i == 8) s_ack_i = 1;
      #1;
      check($sformatf("t5b_c%0d_ack", i), m0_ack_o, (i == 8));
      check($sformatf("t5b_c%0d_err", i), m0_err_o, 1'b0);
      check($sformatf("t5b_c%0d_timeout", i), timeout_o, 1'b0);
    end
    next_cycle();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    next_cycle();
    check("t5b_idle", grant_o, 2'b00);

    // ---- 6: reset asserted mid-burst of m1 ----
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h0000_6000; m1_cti_i = 3'b010;
    next_cycle();
    check("t6_grant_m1", grant_o, 2'b10);
    s_ack_i = 1;
    #1;
    check("t6_beat_ack", m1_ack_o, 1'b1);
    #3;
    wb_rst = 1;
    #1;
    check("t6_async_grant", grant_o, 2'b00);
    check("t6_async_cyc", s_cyc_o, 1'b0);
    check("t6_async_ack", m1_ack_o, 1'b0);
    check("t6_async_adr", s_adr_o, 32'h0);
    s_ack_i = 0;
    next_cycle();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_7000;
    wb_rst = 0;
    next_cycle();
    check("t6_after_rst_m0", grant_o, 2'b01);
    check("t6_after_rst_adr", s_adr_o, 32'h0000_7000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
